// File: rtl/spi_tx_frame_ctrl.sv
// Byte FIFO feeding an external SPI transmitter; whole frames are released only once their
// last byte is queued, and chip select is held high for a guaranteed gap between frames.
module spi_tx_frame_ctrl #(
    parameter int DEPTH  = 8,
    parameter int CS_GAP = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   wr_last,
    input  logic                   err_clr,
    input  logic                   spi_valid,
    output logic [7:0]             spi_data,
    output logic                   spi_cs,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (CS_GAP < 2) ? 1 : $clog2(CS_GAP + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_L   = GW'(CS_GAP);

    // IDLE is encoded as 0 so the debug view reads zero out of reset.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   pend_q, pend_d;
    logic [7:0]      spi_data_q, spi_data_d;
    logic            cur_last_q, cur_last_d;
    logic            spi_cs_q, spi_cs_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

    logic [8:0]      mem_q [DEPTH];
    logic [8:0]      head;
    logic            push;
    logic            pop;
    logic            pend_inc;
    logic            pend_dec;

    assign full      = (level_q == DEPTH_L);
    assign empty     = (level_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign push      = wr_en && !full;
    assign pend_inc  = push && wr_last;
    assign pend_dec  = pop && head[8];

    assign spi_data   = spi_data_q;
    assign spi_cs     = spi_cs_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign level      = level_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

    // Storage carries no reset: occupancy is defined entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_last, wr_data};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        pend_d     = pend_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
        if (pend_inc && !pend_dec) begin
            pend_d = pend_q + LW'(1);
        end else if (!pend_inc && pend_dec) begin
            pend_d = pend_q - LW'(1);
        end
        // A dropped write wins over a simultaneous clear.
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        spi_data_d   = spi_data_q;
        cur_last_d   = cur_last_q;
        spi_cs_d     = spi_cs_q;
        frame_done_d = 1'b0;
        gap_cnt_d    = gap_cnt_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                spi_cs_d = 1'b1;
                // Only complete frames are started, so the FIFO cannot run dry mid-frame.
                if (pend_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                spi_data_d = head[7:0];
                cur_last_d = head[8];
                pop        = 1'b1;
                spi_cs_d   = 1'b0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                spi_cs_d = 1'b0;
                if (spi_valid) begin
                    if (!cur_last_q) begin
                        spi_data_d = head[7:0];
                        cur_last_d = head[8];
                        pop        = 1'b1;
                    end else begin
                        spi_cs_d     = 1'b1;
                        frame_done_d = 1'b1;
                        gap_cnt_d    = GAP_L;
                        state_d      = GAP;
                    end
                end
            end
            GAP: begin
                spi_cs_d = 1'b1;
                if (gap_cnt_q <= GW'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                spi_cs_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pend_q       <= '0;
            spi_data_q   <= 8'h00;
            cur_last_q   <= 1'b0;
            spi_cs_q     <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pend_q       <= pend_d;
            spi_data_q   <= spi_data_d;
            cur_last_q   <= cur_last_d;
            spi_cs_q     <= spi_cs_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_spi_tx_frame_ctrl.sv
// Scoreboard bench: writes push {last,data} into exp_q, a mock transmitter acknowledges bytes,
// and a monitor pops and compares every byte that leaves the block.
module tb_spi_tx_frame_ctrl;

    localparam int DEPTH  = 8;
    localparam int CS_GAP = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_last;
    logic          err_clr;
    logic          auto_valid;
    logic          man_valid;
    logic          spi_valid;
    logic [7:0]    spi_data;
    logic          spi_cs;
    logic          full;
    logic          empty;
    logic          busy;
    logic          frame_done;
    logic          overflow;
    logic [LW-1:0] level;
    logic [1:0]    dbg_state;

    assign spi_valid = auto_valid | man_valid;

    int         checks;
    int         failures;
    logic [8:0] exp_q[$];
    int         fixed_delay;
    bit         xmit_en;
    int         fd_count;
    int         bytes_seen;

    spi_tx_frame_ctrl #(.DEPTH(DEPTH), .CS_GAP(CS_GAP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .err_clr    (err_clr),
        .spi_valid  (spi_valid),
        .spi_data   (spi_data),
        .spi_cs     (spi_cs),
        .full       (full),
        .empty      (empty),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .level      (level),
        .dbg_state  (dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic last, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = last;
        tick();
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (accept) exp_q.push_back({last, d});
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < maxc) begin
            tick();
            n++;
        end
        check(name, int'(n < maxc), 1);
    endtask

    // mock downstream transmitter: acknowledges each byte a programmable number of cycles after it appears
    initial begin : xmit
        int cnt;
        int target;
        auto_valid = 1'b0;
        cnt        = 0;
        target     = 1;
        forever begin
            @(posedge clk);
            #1;
            auto_valid = 1'b0;
            if (!xmit_en || spi_cs !== 1'b0 || !reset_n) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 1) target = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6));
                if (cnt >= target) begin
                    auto_valid = 1'b1;
                    cnt        = 0;
                end
            end
        end
    end

    // monitor: byte order, frame_done placement, gap length, minimum cs-high window
    initial begin : monitor
        logic [8:0] e;
        bit         expect_fd;
        bit         counting;
        int         gap_cnt;
        int         hi_run;
        logic       prev_cs;
        expect_fd = 1'b0;
        counting  = 1'b0;
        gap_cnt   = 0;
        hi_run    = 0;
        prev_cs   = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                expect_fd = 1'b0;
                counting  = 1'b0;
                prev_cs   = 1'b1;
            end else begin
                if (spi_valid && spi_cs === 1'b0) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", spi_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_done_missing", int'(expect_fd), 0);
                        check("tx_byte", int'(spi_data), int'(e[7:0]));
                        expect_fd = e[8];
                    end
                end
                if (frame_done) begin
                    check("frame_done_expected", int'(expect_fd), 1);
                    expect_fd = 1'b0;
                    fd_count++;
                    counting  = 1'b1;
                    gap_cnt   = 1;
                end else if (counting) begin
                    if (busy && spi_cs) begin
                        gap_cnt++;
                    end else begin
                        check("gap_len", gap_cnt, CS_GAP);
                        counting = 1'b0;
                    end
                end
                if (spi_cs) begin
                    hi_run++;
                end else begin
                    if (prev_cs && fd_count > 0) check("cs_high_min", int'(hi_run >= CS_GAP), 1);
                    hi_run = 0;
                end
                prev_cs = spi_cs;
            end
        end
    end

    initial begin : main
        int fd0;
        int b0;
        int len;
        int n;
        checks      = 0;
        failures    = 0;
        fd_count    = 0;
        bytes_seen  = 0;
        reset_n     = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        wr_last     = 1'b0;
        err_clr     = 1'b0;
        man_valid   = 1'b0;
        xmit_en     = 1'b1;
        fixed_delay = 20;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", int'(spi_cs), 1);
        check("rst_data", int'(spi_data), 0);
        check("rst_level", int'(level), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_state", int'(dbg_state), 0);
        reset_n = 1'b1;

        // single frame, first write on the first edge after release
        fd0 = fd_count; b0 = bytes_seen;
        write_byte(8'hA5, 1'b0, 1'b1);
        check("first_write_level", int'(level), 1);
        write_byte(8'h3C, 1'b1, 1'b1);
        wait_idle(200, "single_timeout");
        check("single_bytes", bytes_seen - b0, 2);
        check("single_fd", fd_count - fd0, 1);
        check("single_level", int'(level), 0);

        // partial frame is held back; stray spi_valid in IDLE is ignored
        fixed_delay = 3;
        fd0 = fd_count; b0 = bytes_seen;
        write_byte(8'h11, 1'b0, 1'b1);
        write_byte(8'h22, 1'b0, 1'b1);
        write_byte(8'h33, 1'b0, 1'b1);
        tick(); tick();
        check("partial_cs", int'(spi_cs), 1);
        check("partial_busy", int'(busy), 0);
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        tick();
        check("idle_valid_level", int'(level), 3);
        check("idle_valid_busy", int'(busy), 0);
        write_byte(8'h44, 1'b1, 1'b1);
        tick();
        check("partial_start_busy", int'(busy), 1);
        tick();
        check("partial_start_cs", int'(spi_cs), 0);
        wait_idle(200, "partial_timeout");
        check("partial_bytes", bytes_seen - b0, 4);

        // back-to-back frames
        fd0 = fd_count;
        write_byte(8'h5A, 1'b0, 1'b1);
        write_byte(8'h6B, 1'b1, 1'b1);
        write_byte(8'h7C, 1'b0, 1'b1);
        write_byte(8'h8D, 1'b1, 1'b1);
        wait_idle(200, "b2b_timeout");
        check("b2b_fd", fd_count - fd0, 2);

        // overflow: ninth byte dropped, also when a pop lands in the same cycle
        fixed_delay = 20;
        fd0 = fd_count; b0 = bytes_seen;
        for (int i = 0; i < 7; i++) write_byte(8'h80 + 8'(i), 1'b0, 1'b1);
        write_byte(8'h87, 1'b1, 1'b1);
        write_byte(8'h99, 1'b1, 1'b0);
        check("ovf_level", int'(level), DEPTH);
        check("ovf_full", int'(full), 1);
        check("ovf_flag", int'(overflow), 1);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        err_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        err_clr = 1'b0;
        check("ovf_set_wins", int'(overflow), 1);
        check("ovf_pop_level", int'(level), DEPTH - 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clear", int'(overflow), 0);
        wait_idle(400, "ovf_timeout");
        check("ovf_bytes", bytes_seen - b0, 8);
        check("ovf_fd", fd_count - fd0, 1);

        // write and pop together at level DEPTH-1
        xmit_en = 1'b0;
        fixed_delay = 3;
        fd0 = fd_count;
        for (int i = 0; i < 7; i++) write_byte(8'hC0 + 8'(i), 1'b0, 1'b1);
        write_byte(8'hC7, 1'b1, 1'b1);
        tick(); tick();
        check("sim_pre_level", int'(level), DEPTH - 1);
        check("sim_pre_cs", int'(spi_cs), 0);
        wr_en     = 1'b1;
        wr_data   = 8'hD1;
        wr_last   = 1'b1;
        man_valid = 1'b1;
        tick();
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        man_valid = 1'b0;
        exp_q.push_back({1'b1, 8'hD1});
        check("sim_level", int'(level), DEPTH - 1);
        check("sim_overflow", int'(overflow), 0);
        xmit_en = 1'b1;
        wait_idle(300, "sim_timeout");
        check("sim_fd", fd_count - fd0, 2);

        // asynchronous reset in the middle of a frame
        fixed_delay = 20;
        write_byte(8'hF1, 1'b0, 1'b1);
        write_byte(8'hF2, 1'b0, 1'b1);
        write_byte(8'hF3, 1'b1, 1'b1);
        n = 0;
        while (spi_cs !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check("rst_mid_start", int'(n < 10), 1);
        tick(); tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_cs", int'(spi_cs), 1);
        check("rst_mid_level", int'(level), 0);
        check("rst_mid_state", int'(dbg_state), 0);
        check("rst_mid_empty", int'(empty), 1);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        b0 = bytes_seen;
        repeat (60) tick();
        check("rst_no_retx_bytes", bytes_seen - b0, 0);
        check("rst_no_retx_busy", int'(busy), 0);
        check("rst_no_retx_cs", int'(spi_cs), 1);

        // randomized frames against the queue model
        fixed_delay = 0;
        fd0 = fd_count;
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) begin
                n = 0;
                while (exp_q.size() >= DEPTH && n < 500) begin
                    tick();
                    n++;
                end
                if (n >= 500) check("rand_space_timeout", 0, 1);
                write_byte(8'($urandom_range(0, 255)), (b == len - 1), 1'b1);
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        wait_idle(3000, "rand_timeout");
        check("rand_fd", fd_count - fd0, 40);
        check("rand_level", int'(level), 0);
        check("rand_empty", int'(empty), 1);
        check("rand_overflow", int'(overflow), 0);

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_tx_frame_ctrl.md
SPI_TX_FRAME_CTRL -- requirements
Module: spi_tx_frame_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning byte FIFO depth (power of 2, at least 2).
REQ-002 The block SHALL have parameter CS_GAP, default 4, meaning the minimum number of clk cycles spi_cs is held high between frames (at least 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock, the single clock of the block.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: byte write strobe.
REQ-006 The block SHALL have port wr_data, input, 8 bits: byte to transmit.
REQ-007 The block SHALL have port wr_last, input, 1 bit: the written byte ends a frame.
REQ-008 The block SHALL have port err_clr, input, 1 bit: clears the overflow flag.
REQ-009 The block SHALL have port spi_valid, input, 1 bit: one-cycle byte-done pulse from the downstream SPI transmitter.
REQ-010 The block SHALL have port spi_data, output, 8 bits: byte presented to the transmitter's data_in.
REQ-011 The block SHALL have port spi_cs, output, 1 bit: active-low chip select, driving the transmitter's cs.
REQ-012 The block SHALL have ports full, empty, busy, frame_done and overflow, each output, 1 bit.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-014 The FIFO SHALL store 9-bit entries {last, data} and use wrap-around read/write pointers of $clog2(DEPTH) bits.
REQ-015 A write SHALL be accepted when wr_en=1 and full=0; a write with full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-016 Write and pop in the same cycle with full=0 SHALL leave level unchanged.
REQ-017 full SHALL equal (level==DEPTH) and empty SHALL equal (level==0), both combinational from level.
REQ-018 A frames_pending counter SHALL increment on each accepted write with wr_last=1 and decrement on each pop of a last-flagged entry; increment and decrement in the same cycle SHALL net to zero.
REQ-019 The FSM SHALL have four states: IDLE, LOAD, SHIFT and GAP.
REQ-020 In IDLE with frames_pending>0, the FSM SHALL go to LOAD; otherwise it SHALL stay in IDLE. A frame SHALL never start on a partial frame, so underrun is impossible.
REQ-021 LOAD SHALL last 1 cycle, register the FIFO head into spi_data and its last flag into cur_last, pop the entry, drive spi_cs low, and go to SHIFT.
REQ-022 In SHIFT, spi_cs SHALL stay low and spi_data SHALL stay stable until spi_valid=1.
REQ-023 On spi_valid in SHIFT with cur_last=0, the block SHALL load the next head into spi_data and cur_last in that same cycle, pop it, and stay in SHIFT.
REQ-024 On spi_valid in SHIFT with cur_last=1, the block SHALL drive spi_cs high on the next cycle, pulse frame_done for 1 cycle, and go to GAP.
REQ-025 GAP SHALL hold spi_cs high for exactly CS_GAP cycles using a down-counter, then go to IDLE.
REQ-026 spi_valid SHALL be ignored in IDLE, LOAD and GAP.
REQ-027 busy SHALL be 1 in LOAD, SHIFT and GAP, and 0 in IDLE.
REQ-028 overflow SHALL be sticky and cleared only by err_clr=1 or reset; a simultaneous set and err_clr SHALL leave overflow=1.
REQ-029 spi_cs, spi_data, frame_done and overflow SHALL be registered outputs.

Reset
REQ-030 On reset_n=0, asynchronously, the block SHALL set FSM=IDLE, pointers=0, level=0, frames_pending=0, spi_cs=1, spi_data=8'h00, frame_done=0, overflow=0, busy=0, empty=1 and full=0.
REQ-031 Reset asserted mid-frame SHALL discard all FIFO contents and any pending frame, and spi_cs SHALL rise immediately.
REQ-032 After reset_n deasserts, the block SHALL accept writes on the first clk edge.

Verification
REQ-033 Single frame: write 8'hA5 (last=0) then 8'h3C (last=1), model spi_valid 20 cycles after each byte is presented -> spi_cs low, spi_data=A5 then 3C, one frame_done pulse, spi_cs high for exactly 4 cycles, level=0.
REQ-034 Partial frame: write 3 bytes with last=0 -> spi_cs stays 1 and busy=0; write a 4th byte with last=1 -> the frame starts within 2 cycles and transmits 4 bytes in order.
REQ-035 Overflow: with DEPTH=8, write 9 bytes with no frame pending -> level=8, full=1, overflow=1, and the 9th byte is absent from the output; err_clr=1 -> overflow=0.
REQ-036 Back-to-back frames: queue two 2-byte frames -> two separate spi_cs low windows separated by at least 4 high cycles, and 2 frame_done pulses.
REQ-037 Simultaneous events: write while a pop occurs at level=DEPTH-1 -> level stays at DEPTH-1 and no overflow.
REQ-038 Reset mid-SHIFT: drive reset_n low -> spi_cs=1, level=0 and FSM=IDLE the same cycle; the stale frame is not retransmitted after release.
